// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline; owns the EX multi-cycle occupancy counter.
// Optional stall-cycle statistics counter is built when PIPE_HAZARD_STAT_EN is defined.
module pipe_hazard_ctrl #(
    parameter int MC_CYCLES = 4,
    parameter int CNT_W     = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_load_use,
    input  logic        ex_mc_start,
    input  logic        mem_stall_req,
    input  logic        flush_req,
`ifdef PIPE_HAZARD_STAT_EN
    input  logic        stat_clr,
    output logic [31:0] stat_stall_cycles,
`endif
    output logic [5:0]  stall,
    output logic        flush,
    output logic        ex_mc_done,
    output logic        mc_busy
);

    typedef enum logic {RUN, MC_BUSY} state_t;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_LU   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MC_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    // Outputs are decoded combinationally from state/cnt and the live requests; held at 0 in reset.
    always_comb begin
        stall      = STALL_NONE;
        flush      = 1'b0;
        ex_mc_done = 1'b0;
        state_nxt  = state;
        cnt_nxt    = cnt;
        if (rst) begin
            case (state)
                RUN: begin
                    if (flush_req) begin
                        flush = 1'b1;
                    end else if (mem_stall_req) begin
                        stall = STALL_MEM;
                        if (ex_mc_start) begin
                            state_nxt = MC_BUSY;
                            cnt_nxt   = CNT_LOAD;
                        end
                    end else if (ex_mc_start) begin
                        stall     = STALL_EX;
                        state_nxt = MC_BUSY;
                        cnt_nxt   = CNT_LOAD;
                    end else if (id_load_use) begin
                        stall = STALL_LU;
                    end
                end
                MC_BUSY: begin
                    if (flush_req) begin
                        flush     = 1'b1;
                        state_nxt = RUN;
                        cnt_nxt   = CNT_ZERO;
                    end else if (mem_stall_req) begin
                        stall = STALL_MEM;
                    end else if (cnt == CNT_ONE) begin
                        ex_mc_done = 1'b1;
                        state_nxt  = RUN;
                        cnt_nxt    = CNT_ZERO;
                    end else begin
                        stall   = STALL_EX;
                        cnt_nxt = cnt - CNT_ONE;
                    end
                end
                default: begin
                    state_nxt = RUN;
                    cnt_nxt   = CNT_ZERO;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
            cnt   <= CNT_ZERO;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign mc_busy = (state == MC_BUSY);

`ifdef PIPE_HAZARD_STAT_EN
    // Counts cycles in which the PC is held; clear wins over increment, saturates at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_stall_cycles <= 32'd0;
        end else if (stat_clr) begin
            stat_stall_cycles <= 32'd0;
        end else if (stall[0] && (stat_stall_cycles != 32'hFFFF_FFFF)) begin
            stat_stall_cycles <= stat_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed vectors, literal checks, and a per-cycle model compare.
module tb_pipe_hazard_ctrl;

    localparam int MC = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       id_load_use = 1'b0;
    logic       ex_mc_start = 1'b0;
    logic       mem_stall_req = 1'b0;
    logic       flush_req = 1'b0;
    logic [5:0] stall;
    logic       flush;
    logic       ex_mc_done;
    logic       mc_busy;
`ifdef PIPE_HAZARD_STAT_EN
    logic        stat_clr = 1'b0;
    logic [31:0] stat_stall_cycles;
`endif

    int total = 0;
    int bad   = 0;

    pipe_hazard_ctrl #(.MC_CYCLES(MC), .CNT_W(8)) dut (
        .clk               (clk),
        .rst               (rst),
        .id_load_use       (id_load_use),
        .ex_mc_start       (ex_mc_start),
        .mem_stall_req     (mem_stall_req),
        .flush_req         (flush_req),
`ifdef PIPE_HAZARD_STAT_EN
        .stat_clr          (stat_clr),
        .stat_stall_cycles (stat_stall_cycles),
`endif
        .stall             (stall),
        .flush             (flush),
        .ex_mc_done        (ex_mc_done),
        .mc_busy           (mc_busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic lu, input logic mc, input logic mem, input logic fl);
        @(posedge clk);
        #1;
        id_load_use   = lu;
        ex_mc_start   = mc;
        mem_stall_req = mem;
        flush_req     = fl;
        #1;
    endtask

    // Model: an op in flight is tracked by how many productive cycles it has completed since starting.
    logic       m_busy = 1'b0;
    int         m_prog = 0;
    logic       p_busy = 1'b0;
    int         p_prog = 0;
    longint     m_stat = 0;
    longint     p_stat = 0;

    always @(negedge clk) begin
        logic [5:0] e_stall;
        logic       e_flush;
        logic       e_done;
        e_stall = 6'd0;
        e_flush = 1'b0;
        e_done  = 1'b0;
        p_busy  = m_busy;
        p_prog  = m_prog;
        if (rst) begin
            if (!m_busy) begin
                if (flush_req) e_flush = 1'b1;
                else if (mem_stall_req || ex_mc_start || id_load_use) begin
                    if (mem_stall_req) e_stall = 6'd31;
                    else if (ex_mc_start) e_stall = 6'd15;
                    else e_stall = 6'd7;
                    if (ex_mc_start) begin
                        p_busy = 1'b1;
                        p_prog = 0;
                    end
                end
            end else begin
                if (flush_req) begin
                    e_flush = 1'b1;
                    p_busy  = 1'b0;
                end else if (mem_stall_req) begin
                    e_stall = 6'd31;
                end else if (m_prog + 2 == MC) begin
                    e_done = 1'b1;
                    p_busy = 1'b0;
                end else begin
                    e_stall = 6'd15;
                    p_prog  = m_prog + 1;
                end
            end
        end
        checkOutput("stall", {26'd0, stall}, {26'd0, e_stall});
        checkOutput("flush", {31'd0, flush}, {31'd0, e_flush});
        checkOutput("ex_mc_done", {31'd0, ex_mc_done}, {31'd0, e_done});
        checkOutput("mc_busy", {31'd0, mc_busy}, {31'd0, (rst ? m_busy : 1'b0)});
        p_stat = m_stat;
`ifdef PIPE_HAZARD_STAT_EN
        checkOutput("stat_stall_cycles", stat_stall_cycles, m_stat[31:0]);
        if (stat_clr) p_stat = 0;
        else if (e_stall[0] && m_stat < 64'hFFFF_FFFF) p_stat = m_stat + 1;
`endif
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy = 1'b0;
            m_prog = 0;
            m_stat = 0;
        end else begin
            m_busy = p_busy;
            m_prog = p_prog;
            m_stat = p_stat;
        end
    end

    initial begin
        // Reset state while rst is low.
        #2;
        checkOutput("rst_stall", {26'd0, stall}, 32'd0);
        checkOutput("rst_busy", {31'd0, mc_busy}, 32'd0);
        #20;
        rst = 1'b1;

        // Load-use: one bubble cycle, then clear.
        applyStimulus(1, 0, 0, 0);
        checkOutput("lu_stall", {26'd0, stall}, 32'h07);
        applyStimulus(0, 0, 0, 0);
        checkOutput("lu_after", {26'd0, stall}, 32'h00);

        // Uninterrupted multi-cycle op.
        applyStimulus(0, 1, 0, 0);
        checkOutput("mc_c0_stall", {26'd0, stall}, 32'h0F);
        checkOutput("mc_c0_busy", {31'd0, mc_busy}, 32'd0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("mc_c1_stall", {26'd0, stall}, 32'h0F);
        checkOutput("mc_c1_busy", {31'd0, mc_busy}, 32'd1);
        applyStimulus(0, 1, 0, 0);
        checkOutput("mc_c2_stall", {26'd0, stall}, 32'h0F);
        applyStimulus(0, 0, 0, 0);
        checkOutput("mc_c3_done", {31'd0, ex_mc_done}, 32'd1);
        checkOutput("mc_c3_stall", {26'd0, stall}, 32'h00);
        applyStimulus(0, 0, 0, 0);
        checkOutput("mc_c4_busy", {31'd0, mc_busy}, 32'd0);

        // MEM wait during the op pushes completion out to cycle 5.
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 0, 1, 0);
        checkOutput("mw_c1_stall", {26'd0, stall}, 32'h1F);
        applyStimulus(0, 0, 1, 0);
        checkOutput("mw_c2_stall", {26'd0, stall}, 32'h1F);
        applyStimulus(0, 0, 0, 0);
        checkOutput("mw_c3_stall", {26'd0, stall}, 32'h0F);
        applyStimulus(0, 0, 0, 0);
        checkOutput("mw_c4_done", {31'd0, ex_mc_done}, 32'd0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("mw_c5_done", {31'd0, ex_mc_done}, 32'd1);

        // Start coincident with a MEM wait in RUN still enters the op.
        applyStimulus(0, 1, 1, 0);
        checkOutput("ms_c0_stall", {26'd0, stall}, 32'h1F);
        applyStimulus(0, 0, 0, 0);
        checkOutput("ms_c1_busy", {31'd0, mc_busy}, 32'd1);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("ms_c3_done", {31'd0, ex_mc_done}, 32'd1);

        // Flush aborts the op in its cycle 2.
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("ab_flush", {31'd0, flush}, 32'd1);
        checkOutput("ab_stall", {26'd0, stall}, 32'h00);
        checkOutput("ab_done", {31'd0, ex_mc_done}, 32'd0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("ab_c3_busy", {31'd0, mc_busy}, 32'd0);
        repeat (4) applyStimulus(0, 0, 0, 0);

        // Flush beats start and load-use together.
        applyStimulus(1, 1, 0, 1);
        checkOutput("pr_flush", {31'd0, flush}, 32'd1);
        checkOutput("pr_stall", {26'd0, stall}, 32'h00);
        applyStimulus(0, 0, 0, 0);
        checkOutput("pr_busy", {31'd0, mc_busy}, 32'd0);

        // Asynchronous reset while busy with cnt=2.
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("mr_pre_stall", {26'd0, stall}, 32'h0F);
        rst = 1'b0;
        #1;
        checkOutput("mr_stall", {26'd0, stall}, 32'h00);
        checkOutput("mr_flush", {31'd0, flush}, 32'd0);
        checkOutput("mr_done", {31'd0, ex_mc_done}, 32'd0);
        checkOutput("mr_busy", {31'd0, mc_busy}, 32'd0);
        #1;
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0);
        checkOutput("mr_idle_stall", {26'd0, stall}, 32'h00);
        checkOutput("mr_idle_done", {31'd0, ex_mc_done}, 32'd0);

        // Mixed traffic, checked by the per-cycle model.
        for (int i = 0; i < 300; i++) begin
            logic mc_pulse;
            mc_pulse = ($urandom_range(0, 5) == 0) && !ex_mc_start;
`ifdef PIPE_HAZARD_STAT_EN
            stat_clr = ($urandom_range(0, 40) == 0);
`endif
            applyStimulus($urandom_range(0, 3) == 0, mc_pulse,
                          $urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0);
        end
        applyStimulus(0, 0, 0, 0);
        @(posedge clk);
        #2;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
